axil_xbar: RTL and testbench

AXIL_XBAR -- requirements
Module: axil_xbar

---
 rtl/axil_xbar_pkg.sv | 21 ++
 rtl/axil_addr_decode.sv | 37 +++
 rtl/axil_xbar.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axil_xbar.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_xbar_pkg.sv
// Shared types and constants for the AXI4-lite crossbar: response codes,
// read/write FSM state encodings and the master identifier.
package axil_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wr_state_e;
    typedef enum logic {MID_M0 = 1'b0, MID_M1 = 1'b1} mid_e;

    // Round-robin pick between the two read masters; on a collision the
    // master that was not granted last wins.
    function automatic mid_e rr_pick(input logic v0, input logic v1, input mid_e last);
        if (v0 && v1) begin
            return (last == MID_M0) ? MID_M1 : MID_M0;
        end
        return (v1 && !v0) ? MID_M1 : MID_M0;
    endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Combinational address decoder: one-hot slave select plus a miss flag.
// Disabled slaves never match; on overlapping windows the lowest index wins.
module axil_addr_decode
    import axil_xbar_pkg::*;
#(
    parameter int                          AXI_AWIDTH = 32,
    parameter int                          NUM_S      = 3,
    parameter logic [NUM_S-1:0]            S_EN       = '1,
    parameter logic [NUM_S*AXI_AWIDTH-1:0] S_START    = {32'hF0000000, 32'h40000000, 32'h00000000},
    parameter logic [NUM_S*AXI_AWIDTH-1:0] S_END      = {32'hF0000007, 32'h4000000F, 32'h3FFFFFF0}
) (
    input  logic [AXI_AWIDTH-1:0] addr_i,
    output logic [NUM_S-1:0]      sel_o,
    output logic                  miss_o
);

    logic                  found;
    logic [AXI_AWIDTH-1:0] lo;
    logic [AXI_AWIDTH-1:0] hi;

    always_comb begin
        sel_o = '0;
        found = 1'b0;
        lo    = '0;
        hi    = '0;
        for (int i = 0; i < NUM_S; i++) begin
            lo = S_START[i*AXI_AWIDTH +: AXI_AWIDTH];
            hi = S_END[i*AXI_AWIDTH +: AXI_AWIDTH];
            if (!found && S_EN[i] && (addr_i >= lo) && (addr_i <= hi)) begin
                sel_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        miss_o = !found;
    end

endmodule

// File: rtl/axil_xbar.sv
// AXI4-lite crossbar: host master M0 (read/write) and fetch master M1 (read)
// onto NUM_S slaves, with independent single-outstanding read and write paths.
module axil_xbar
    import axil_xbar_pkg::*;
#(
    parameter int                          AXI_AWIDTH = 32,
    parameter int                          AXI_DWIDTH = 32,
    parameter int                          NUM_S      = 3,
    parameter logic [NUM_S-1:0]            S_EN       = '1,
    parameter logic [NUM_S*AXI_AWIDTH-1:0] S_START    = {32'hF0000000, 32'h40000000, 32'h00000000},
    parameter logic [NUM_S*AXI_AWIDTH-1:0] S_END      = {32'hF0000007, 32'h4000000F, 32'h3FFFFFF0}
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [AXI_AWIDTH-1:0]           M0_AWADDR,
    input  logic                            M0_AWVALID,
    output logic                            M0_AWREADY,
    input  logic [AXI_DWIDTH-1:0]           M0_WDATA,
    input  logic [AXI_DWIDTH/8-1:0]         M0_WSTRB,
    input  logic                            M0_WVALID,
    output logic                            M0_WREADY,
    output logic [1:0]                      M0_BRESP,
    output logic                            M0_BVALID,
    input  logic                            M0_BREADY,
    input  logic [AXI_AWIDTH-1:0]           M0_ARADDR,
    input  logic                            M0_ARVALID,
    output logic                            M0_ARREADY,
    output logic [AXI_DWIDTH-1:0]           M0_RDATA,
    output logic [1:0]                      M0_RRESP,
    output logic                            M0_RVALID,
    input  logic                            M0_RREADY,
    input  logic [AXI_AWIDTH-1:0]           M1_ARADDR,
    input  logic                            M1_ARVALID,
    output logic                            M1_ARREADY,
    output logic [AXI_DWIDTH-1:0]           M1_RDATA,
    output logic [1:0]                      M1_RRESP,
    output logic                            M1_RVALID,
    input  logic                            M1_RREADY,
    output logic [NUM_S*AXI_AWIDTH-1:0]     S_AWADDR,
    output logic [NUM_S-1:0]                S_AWVALID,
    input  logic [NUM_S-1:0]                S_AWREADY,
    output logic [NUM_S*AXI_DWIDTH-1:0]     S_WDATA,
    output logic [NUM_S*AXI_DWIDTH/8-1:0]   S_WSTRB,
    output logic [NUM_S-1:0]                S_WVALID,
    input  logic [NUM_S-1:0]                S_WREADY,
    input  logic [NUM_S*2-1:0]              S_BRESP,
    input  logic [NUM_S-1:0]                S_BVALID,
    output logic [NUM_S-1:0]                S_BREADY,
    output logic [NUM_S*AXI_AWIDTH-1:0]     S_ARADDR,
    output logic [NUM_S-1:0]                S_ARVALID,
    input  logic [NUM_S-1:0]                S_ARREADY,
    input  logic [NUM_S*AXI_DWIDTH-1:0]     S_RDATA,
    input  logic [NUM_S*2-1:0]              S_RRESP,
    input  logic [NUM_S-1:0]                S_RVALID,
    output logic [NUM_S-1:0]                S_RREADY
);

    rd_state_e               rd_state_q, rd_state_d;
    mid_e                    rd_mid_q, rd_mid_d;
    mid_e                    rr_last_q, rr_last_d;
    logic [AXI_AWIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [NUM_S-1:0]        rd_sel_q, rd_sel_d;

    wr_state_e               wr_state_q, wr_state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [AXI_AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [AXI_DWIDTH-1:0]   wr_data_q, wr_data_d;
    logic [AXI_DWIDTH/8-1:0] wr_strb_q, wr_strb_d;
    logic [NUM_S-1:0]        wr_sel_q, wr_sel_d;

    mid_e                    rd_win;
    logic [AXI_AWIDTH-1:0]   rd_win_addr;
    logic [NUM_S-1:0]        rd_dec_sel, wr_dec_sel;
    logic                    rd_dec_miss, wr_dec_miss;
    logic                    rd_mready, rd_vld;
    logic [AXI_DWIDTH-1:0]   rd_data;
    logic [1:0]              rd_resp;
    logic                    rs_valid, bs_valid;
    logic [AXI_DWIDTH-1:0]   rs_data;
    logic [1:0]              rs_resp, bs_resp;

    assign rd_win      = rr_pick(M0_ARVALID, M1_ARVALID, rr_last_q);
    assign rd_win_addr = (rd_win == MID_M1) ? M1_ARADDR : M0_ARADDR;

    // Read path decodes the arbitration winner; write path decodes the held AW.
    axil_addr_decode #(
        .AXI_AWIDTH (AXI_AWIDTH),
        .NUM_S      (NUM_S),
        .S_EN       (S_EN),
        .S_START    (S_START),
        .S_END      (S_END)
    ) u_rd_dec (
        .addr_i (rd_win_addr),
        .sel_o  (rd_dec_sel),
        .miss_o (rd_dec_miss)
    );

    axil_addr_decode #(
        .AXI_AWIDTH (AXI_AWIDTH),
        .NUM_S      (NUM_S),
        .S_EN       (S_EN),
        .S_START    (S_START),
        .S_END      (S_END)
    ) u_wr_dec (
        .addr_i (wr_addr_q),
        .sel_o  (wr_dec_sel),
        .miss_o (wr_dec_miss)
    );

    assign S_ARADDR = {NUM_S{rd_addr_q}};
    assign S_AWADDR = {NUM_S{wr_addr_q}};
    assign S_WDATA  = {NUM_S{wr_data_q}};
    assign S_WSTRB  = {NUM_S{wr_strb_q}};

    always_comb begin
        rs_valid = 1'b0;
        rs_data  = '0;
        rs_resp  = '0;
        bs_valid = 1'b0;
        bs_resp  = '0;
        for (int i = 0; i < NUM_S; i++) begin
            if (rd_sel_q[i]) begin
                rs_valid = rs_valid | S_RVALID[i];
                rs_data  = rs_data | S_RDATA[i*AXI_DWIDTH +: AXI_DWIDTH];
                rs_resp  = rs_resp | S_RRESP[2*i +: 2];
            end
            if (wr_sel_q[i]) begin
                bs_valid = bs_valid | S_BVALID[i];
                bs_resp  = bs_resp | S_BRESP[2*i +: 2];
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_mid_d   = rd_mid_q;
        rr_last_d  = rr_last_q;
        rd_addr_d  = rd_addr_q;
        rd_sel_d   = rd_sel_q;
        M0_ARREADY = 1'b0;
        M1_ARREADY = 1'b0;
        S_ARVALID  = '0;
        S_RREADY   = '0;
        rd_vld     = 1'b0;
        rd_data    = '0;
        rd_resp    = RESP_OKAY;
        rd_mready  = (rd_mid_q == MID_M1) ? M1_RREADY : M0_RREADY;
        case (rd_state_q)
            R_IDLE: begin
                if (!ARESET && (M0_ARVALID || M1_ARVALID)) begin
                    M0_ARREADY = (rd_win == MID_M0);
                    M1_ARREADY = (rd_win == MID_M1);
                    rd_mid_d   = rd_win;
                    rr_last_d  = rd_win;
                    rd_addr_d  = rd_win_addr;
                    rd_sel_d   = rd_dec_sel;
                    rd_state_d = rd_dec_miss ? R_ERR : R_ADDR;
                end
            end
            R_ADDR: begin
                S_ARVALID = rd_sel_q;
                if (|(S_ARREADY & rd_sel_q)) begin
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rd_vld   = rs_valid;
                rd_data  = rs_data;
                rd_resp  = rs_resp;
                S_RREADY = rd_sel_q & {NUM_S{rd_mready}};
                if (rs_valid && rd_mready) begin
                    rd_state_d = R_IDLE;
                end
            end
            R_ERR: begin
                rd_vld  = 1'b1;
                rd_resp = RESP_DECERR;
                if (rd_mready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        M0_RVALID = rd_vld && (rd_mid_q == MID_M0);
        M1_RVALID = rd_vld && (rd_mid_q == MID_M1);
        M0_RDATA  = (rd_mid_q == MID_M0) ? rd_data : '0;
        M1_RDATA  = (rd_mid_q == MID_M1) ? rd_data : '0;
        M0_RRESP  = (rd_mid_q == MID_M0) ? rd_resp : RESP_OKAY;
        M1_RRESP  = (rd_mid_q == MID_M1) ? rd_resp : RESP_OKAY;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        wr_sel_d   = wr_sel_q;
        M0_AWREADY = 1'b0;
        M0_WREADY  = 1'b0;
        M0_BVALID  = 1'b0;
        M0_BRESP   = RESP_OKAY;
        S_AWVALID  = '0;
        S_WVALID   = '0;
        S_BREADY   = '0;
        case (wr_state_q)
            W_IDLE: begin
                M0_AWREADY = !aw_held_q && !ARESET;
                M0_WREADY  = !w_held_q && !ARESET;
                if (M0_AWVALID && M0_AWREADY) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = M0_AWADDR;
                end
                if (M0_WVALID && M0_WREADY) begin
                    w_held_d  = 1'b1;
                    wr_data_d = M0_WDATA;
                    wr_strb_d = M0_WSTRB;
                end
                // Decode only once both halves are held, one cycle after the later one.
                if (aw_held_q && w_held_q) begin
                    wr_sel_d   = wr_dec_sel;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = wr_dec_miss ? W_ERR : W_FWD;
                end
            end
            W_FWD: begin
                S_AWVALID = wr_sel_q & {NUM_S{!aw_done_q}};
                S_WVALID  = wr_sel_q & {NUM_S{!w_done_q}};
                aw_done_d = aw_done_q || (|(S_AWVALID & S_AWREADY));
                w_done_d  = w_done_q || (|(S_WVALID & S_WREADY));
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                M0_BVALID = bs_valid;
                M0_BRESP  = bs_resp;
                S_BREADY  = wr_sel_q & {NUM_S{M0_BREADY}};
                if (bs_valid && M0_BREADY) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            W_ERR: begin
                M0_BVALID = 1'b1;
                M0_BRESP  = RESP_DECERR;
                if (M0_BREADY) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            rd_mid_q   <= MID_M0;
            rr_last_q  <= MID_M1;
            rd_addr_q  <= '0;
            rd_sel_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_mid_q   <= rd_mid_d;
            rr_last_q  <= rr_last_d;
            rd_addr_q  <= rd_addr_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_sel_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            wr_sel_q   <= wr_sel_d;
        end
    end

endmodule

// File: tb/tb_axil_xbar.sv
// Directed bench for axil_xbar: default three-slave map plus a second instance
// with slave 2 disabled; slave models return addr ^ ((index+1) << 28).
module tb_axil_xbar;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_awaddr = '0, m0_araddr = '0, m1_araddr = '0;
    logic          m0_awvalid = 0, m0_wvalid = 0, m0_bready = 0, m0_arvalid = 0, m0_rready = 0;
    logic          m1_arvalid = 0, m1_rready = 0;
    logic [DW-1:0] m0_wdata = '0;
    logic [3:0]    m0_wstrb = '0;
    logic          m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid, m1_arready, m1_rvalid;
    logic [1:0]    m0_bresp, m0_rresp, m1_rresp;
    logic [DW-1:0] m0_rdata, m1_rdata;

    logic [NS*AW-1:0] s_awaddr, s_araddr;
    logic [NS*DW-1:0] s_wdata, s_rdata;
    logic [NS*4-1:0]  s_wstrb;
    logic [NS*2-1:0]  s_bresp, s_rresp;
    logic [NS-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [NS-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;

    axil_xbar dut (
        .ACLK(clk), .ARESET(rst),
        .M0_AWADDR(m0_awaddr), .M0_AWVALID(m0_awvalid), .M0_AWREADY(m0_awready),
        .M0_WDATA(m0_wdata), .M0_WSTRB(m0_wstrb), .M0_WVALID(m0_wvalid), .M0_WREADY(m0_wready),
        .M0_BRESP(m0_bresp), .M0_BVALID(m0_bvalid), .M0_BREADY(m0_bready),
        .M0_ARADDR(m0_araddr), .M0_ARVALID(m0_arvalid), .M0_ARREADY(m0_arready),
        .M0_RDATA(m0_rdata), .M0_RRESP(m0_rresp), .M0_RVALID(m0_rvalid), .M0_RREADY(m0_rready),
        .M1_ARADDR(m1_araddr), .M1_ARVALID(m1_arvalid), .M1_ARREADY(m1_arready),
        .M1_RDATA(m1_rdata), .M1_RRESP(m1_rresp), .M1_RVALID(m1_rvalid), .M1_RREADY(m1_rready),
        .S_AWADDR(s_awaddr), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
        .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .S_ARADDR(s_araddr), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready)
    );

    // Second instance: slave 2 removed from the map, slave side tied off.
    logic [AW-1:0]    d2_araddr = '0;
    logic             d2_arvalid = 0, d2_rready = 0;
    logic             d2_awready, d2_wready, d2_bvalid, d2_arready, d2_rvalid, d2_m1_arready, d2_m1_rvalid;
    logic [1:0]       d2_bresp, d2_rresp, d2_m1_rresp;
    logic [DW-1:0]    d2_rdata, d2_m1_rdata;
    logic [NS*AW-1:0] d2_s_awaddr, d2_s_araddr;
    logic [NS*DW-1:0] d2_s_wdata;
    logic [NS*4-1:0]  d2_s_wstrb;
    logic [NS-1:0]    d2_s_awvalid, d2_s_wvalid, d2_s_bready, d2_s_arvalid, d2_s_rready;

    axil_xbar #(.S_EN(3'b011)) dut2 (
        .ACLK(clk), .ARESET(rst),
        .M0_AWADDR('0), .M0_AWVALID(1'b0), .M0_AWREADY(d2_awready),
        .M0_WDATA('0), .M0_WSTRB('0), .M0_WVALID(1'b0), .M0_WREADY(d2_wready),
        .M0_BRESP(d2_bresp), .M0_BVALID(d2_bvalid), .M0_BREADY(1'b0),
        .M0_ARADDR(d2_araddr), .M0_ARVALID(d2_arvalid), .M0_ARREADY(d2_arready),
        .M0_RDATA(d2_rdata), .M0_RRESP(d2_rresp), .M0_RVALID(d2_rvalid), .M0_RREADY(d2_rready),
        .M1_ARADDR('0), .M1_ARVALID(1'b0), .M1_ARREADY(d2_m1_arready),
        .M1_RDATA(d2_m1_rdata), .M1_RRESP(d2_m1_rresp), .M1_RVALID(d2_m1_rvalid), .M1_RREADY(1'b0),
        .S_AWADDR(d2_s_awaddr), .S_AWVALID(d2_s_awvalid), .S_AWREADY('0),
        .S_WDATA(d2_s_wdata), .S_WSTRB(d2_s_wstrb), .S_WVALID(d2_s_wvalid), .S_WREADY('0),
        .S_BRESP('0), .S_BVALID('0), .S_BREADY(d2_s_bready),
        .S_ARADDR(d2_s_araddr), .S_ARVALID(d2_s_arvalid), .S_ARREADY('0),
        .S_RDATA('0), .S_RRESP('0), .S_RVALID('0), .S_RREADY(d2_s_rready)
    );

    // Zero-wait slave models.
    logic [NS-1:0] aw_got, w_got, bv_q, rv_q;
    logic [DW-1:0] rd_q [NS];
    logic [AW-1:0] last_aw [NS];
    logic [DW-1:0] last_w [NS];
    int            aw_cnt [NS];
    int            ar_cnt [NS];
    int            d2_arv_cnt = 0;

    assign s_awready = '1;
    assign s_wready  = '1;
    assign s_arready = '1;
    assign s_bresp   = '0;
    assign s_rresp   = '0;
    assign s_bvalid  = bv_q;
    assign s_rvalid  = rv_q;
    always_comb for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = rd_q[i];

    initial for (int i = 0; i < NS; i++) begin
        aw_cnt[i] = 0; ar_cnt[i] = 0; rd_q[i] = '0; last_aw[i] = '0; last_w[i] = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            aw_got <= '0; w_got <= '0; bv_q <= '0; rv_q <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (s_arvalid[i]) begin
                    rv_q[i] <= 1'b1;
                    rd_q[i] <= s_araddr[i*AW +: AW] ^ (32'(i + 1) << 28);
                    ar_cnt[i] <= ar_cnt[i] + 1;
                end else if (rv_q[i] && s_rready[i]) begin
                    rv_q[i] <= 1'b0;
                end
                if (s_awvalid[i]) begin
                    aw_got[i] <= 1'b1; last_aw[i] <= s_awaddr[i*AW +: AW]; aw_cnt[i] <= aw_cnt[i] + 1;
                end
                if (s_wvalid[i]) begin
                    w_got[i] <= 1'b1; last_w[i] <= s_wdata[i*DW +: DW];
                end
                if (aw_got[i] && w_got[i] && !bv_q[i]) begin
                    bv_q[i] <= 1'b1; aw_got[i] <= 1'b0; w_got[i] <= 1'b0;
                end
                if (bv_q[i] && s_bready[i]) bv_q[i] <= 1'b0;
            end
        end
        if (|d2_s_arvalid) d2_arv_cnt <= d2_arv_cnt + 1;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_read(input int m, input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output time acc_t, output int lat);
        bit hs = 0;
        int n = 0;
        data = '0; resp = '0; lat = -1; acc_t = 0;
        if (m == 0) begin m0_araddr = addr; m0_arvalid = 1; end
        else        begin m1_araddr = addr; m1_arvalid = 1; end
        while (!hs && n < 50) begin
            @(negedge clk); hs = (m == 0) ? m0_arready : m1_arready;
            @(posedge clk); n++;
        end
        acc_t = $time;
        #1;
        if (m == 0) m0_arvalid = 0; else m1_arvalid = 0;
        if (!hs) check_val("ar_timeout", 0, 1);
        if (m == 0) m0_rready = 1; else m1_rready = 1;
        hs = 0; n = 0;
        while (n < 50) begin
            @(negedge clk);
            if ((m == 0) ? m0_rvalid : m1_rvalid) begin
                hs = 1;
                data = (m == 0) ? m0_rdata : m1_rdata;
                resp = (m == 0) ? m0_rresp : m1_rresp;
                break;
            end
            @(posedge clk); n++;
        end
        lat = n;
        if (!hs) check_val("r_timeout", 0, 1);
        @(posedge clk); #1;
        if (m == 0) m0_rready = 0; else m1_rready = 0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int w_lead,
                            output logic [1:0] resp);
        bit hs = 0;
        int n = 0;
        fork
            begin
                bit whs = 0;
                int wn = 0;
                m0_wdata = data; m0_wstrb = 4'hF; m0_wvalid = 1;
                while (!whs && wn < 50) begin
                    @(negedge clk); whs = m0_wready; @(posedge clk); wn++;
                end
                #1 m0_wvalid = 0;
                if (!whs) check_val("w_timeout", 0, 1);
            end
            begin
                bit ahs = 0;
                int an = 0;
                if (w_lead > 0) begin repeat (w_lead) @(posedge clk); #1; end
                m0_awaddr = addr; m0_awvalid = 1;
                while (!ahs && an < 50) begin
                    @(negedge clk); ahs = m0_awready; @(posedge clk); an++;
                end
                #1 m0_awvalid = 0;
                if (!ahs) check_val("aw_timeout", 0, 1);
            end
        join
        m0_bready = 1;
        resp = '0;
        while (n < 50) begin
            @(negedge clk);
            if (m0_bvalid) begin hs = 1; resp = m0_bresp; break; end
            @(posedge clk); n++;
        end
        if (!hs) check_val("b_timeout", 0, 1);
        @(posedge clk); #1 m0_bready = 0;
    endtask

    logic [31:0] rd0, rd1;
    logic [1:0]  rr0, rr1, br;
    time         t0, t1;
    int          l0, l1, cnt_save;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Valids high during reset must not be accepted.
        m0_arvalid = 1; m1_arvalid = 1; m0_awvalid = 1; m0_wvalid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_m0_arready", m0_arready, 0);
        check_val("rst_m1_arready", m1_arready, 0);
        check_val("rst_awready", m0_awready, 0);
        check_val("rst_wready", m0_wready, 0);
        @(posedge clk); #1;
        m0_arvalid = 0; m1_arvalid = 0; m0_awvalid = 0; m0_wvalid = 0;
        rst = 0;
        @(negedge clk);
        check_val("idle_s_arvalid", s_arvalid, 0);
        check_val("idle_s_awvalid", s_awvalid, 0);
        check_val("idle_m0_rvalid", m0_rvalid, 0);
        check_val("idle_m0_bvalid", m0_bvalid, 0);
        check_val("idle_m0_rdata", m0_rdata, 0);
        check_val("idle_m0_bresp", m0_bresp, 0);
        check_val("idle_awready", m0_awready, 1);
        @(posedge clk); #1;

        // Arbitration: first collision goes to M0, then M1.
        fork
            do_read(0, 32'h100, rd0, rr0, t0, l0);
            do_read(1, 32'h200, rd1, rr1, t1, l1);
        join
        check_val("col1_m0_first", t0 < t1, 1);
        check_val("col1_m0_data", rd0, 32'h10000100);
        check_val("col1_m1_data", rd1, 32'h10000200);
        check_val("col1_m1_resp", rr1, 0);
        fork
            do_read(0, 32'h104, rd0, rr0, t0, l0);
            do_read(1, 32'h204, rd1, rr1, t1, l1);
        join
        check_val("col2_m0_first", t0 < t1, 1);
        do_read(0, 32'h0, rd0, rr0, t0, l0);
        fork
            do_read(0, 32'h108, rd0, rr0, t0, l0);
            do_read(1, 32'h208, rd1, rr1, t1, l1);
        join
        check_val("col3_m1_first", t1 < t0, 1);
        check_val("col3_m1_data", rd1, 32'h10000208);

        // Write with W leading AW by two cycles.
        cnt_save = aw_cnt[1];
        do_write(32'h40000004, 32'h000000A5, 2, br);
        check_val("wr_s1_addr", last_aw[1], 32'h40000004);
        check_val("wr_s1_data", last_w[1], 32'h000000A5);
        check_val("wr_s1_cnt", aw_cnt[1] - cnt_save, 1);
        check_val("wr_bresp", br, 2'b00);

        // Decode boundaries.
        cnt_save = ar_cnt[0];
        do_read(0, 32'h3FFFFFF0, rd0, rr0, t0, l0);
        check_val("s0_end_data", rd0, 32'h2FFFFFF0);
        check_val("s0_end_lat", l0, 1);
        check_val("s0_end_cnt", ar_cnt[0] - cnt_save, 1);
        cnt_save = ar_cnt[0] + ar_cnt[1] + ar_cnt[2];
        do_read(0, 32'h3FFFFFF4, rd0, rr0, t0, l0);
        check_val("gap_resp", rr0, 2'b11);
        check_val("gap_data", rd0, 0);
        check_val("gap_no_slave", ar_cnt[0] + ar_cnt[1] + ar_cnt[2] - cnt_save, 0);
        do_read(0, 32'h4000000F, rd0, rr0, t0, l0);
        check_val("s1_end_data", rd0, 32'h6000000F);
        check_val("s1_end_resp", rr0, 2'b00);
        do_read(1, 32'hF0000004, rd1, rr1, t1, l1);
        check_val("s2_m1_data", rd1, 32'hC0000004);
        cnt_save = aw_cnt[0] + aw_cnt[1] + aw_cnt[2];
        do_write(32'h50000000, 32'h1, 0, br);
        check_val("wr_err_bresp", br, 2'b11);
        check_val("wr_err_no_slave", aw_cnt[0] + aw_cnt[1] + aw_cnt[2] - cnt_save, 0);

        // Concurrent write (M0) and read (M1) to slave 0.
        fork
            do_write(32'h10, 32'h00001234, 0, br);
            do_read(1, 32'h20, rd1, rr1, t1, l1);
        join
        check_val("conc_bresp", br, 2'b00);
        check_val("conc_rresp", rr1, 2'b00);
        check_val("conc_rdata", rd1, 32'h10000020);
        check_val("conc_waddr", last_aw[0], 32'h10);
        check_val("conc_wdata", last_w[0], 32'h00001234);

        // Reset while the slave holds RVALID and M0 withholds RREADY.
        m0_araddr = 32'h0; m0_arvalid = 1;
        l0 = 0;
        while (l0 < 50) begin
            @(negedge clk); if (m0_arready) break;
            @(posedge clk); l0++;
        end
        @(posedge clk); #1 m0_arvalid = 0;
        l0 = 0;
        while (l0 < 50) begin
            @(negedge clk); if (m0_rvalid) break;
            @(posedge clk); l0++;
        end
        check_val("pre_rst_rvalid", m0_rvalid, 1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check_val("post_rst_rvalid", m0_rvalid, 0);
        check_val("post_rst_s_arvalid", s_arvalid, 0);
        check_val("post_rst_s_rready", s_rready, 0);
        @(posedge clk); #1;
        do_read(0, 32'h0, rd0, rr0, t0, l0);
        check_val("post_rst_rd_data", rd0, 32'h10000000);
        check_val("post_rst_rd_resp", rr0, 2'b00);

        // Disabled slave decodes to DECERR without touching any slave.
        d2_araddr = 32'hF0000000; d2_arvalid = 1;
        l0 = 0;
        while (l0 < 50) begin
            @(negedge clk); if (d2_arready) break;
            @(posedge clk); l0++;
        end
        check_val("d2_arready", d2_arready, 1);
        @(posedge clk); #1 d2_arvalid = 0; d2_rready = 1;
        l0 = 0;
        while (l0 < 50) begin
            @(negedge clk); if (d2_rvalid) break;
            @(posedge clk); l0++;
        end
        check_val("d2_rvalid", d2_rvalid, 1);
        check_val("d2_rresp", d2_rresp, 2'b11);
        check_val("d2_rdata", d2_rdata, 0);
        @(posedge clk); #1 d2_rready = 0;
        @(posedge clk); #1;
        check_val("d2_no_s_arvalid", d2_arv_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
